// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// buffers the returned word for decode, follows redirects and halts on a
// misaligned address or on a memory request that is never acknowledged.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fault
);

  // Counter holds 0 .. ACK_TIMEOUT-1 waiting cycles.
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      pc_last;
  logic             launch;
  logic [31:0]      launch_addr;

  // Decide whether a fresh request is launched at the next edge, and where to.
  always_comb begin
    launch      = 1'b0;
    launch_addr = pc_in;
    case (state)
      S_IDLE: begin
        launch      = 1'b1;
        launch_addr = redirect ? redirect_pc : pc_in;
      end
      S_REQ: begin
        if (redirect && imem_ack) begin
          launch      = 1'b1;
          launch_addr = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          launch      = 1'b1;
          launch_addr = redirect_pc;
        end else if (instr_ready) begin
          launch = 1'b1;
        end
      end
      S_DRAIN: begin
        // Stale request completes; a same-cycle redirect wins over pc_in.
        if (imem_ack) begin
          launch      = 1'b1;
          launch_addr = redirect ? redirect_pc : pc_in;
        end
      end
      default: begin
        launch = 1'b0;
      end
    endcase
  end

  // Same-cycle program-counter load strobe; pc_next holds its last value otherwise.
  always_comb begin
    pc_en   = 1'b0;
    pc_next = pc_last;
    if (reset && (state != S_HALT)) begin
      if (redirect) begin
        pc_en   = 1'b1;
        pc_next = redirect_pc;
      end else if ((state == S_REQ) && imem_ack) begin
        pc_en   = 1'b1;
        pc_next = imem_addr + 32'd4;
      end
    end
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      pc_last     <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0000_0000;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      fault       <= 1'b0;
    end else begin
      if (pc_en) begin
        pc_last <= pc_next;
      end
      if (launch) begin
        instr_valid <= 1'b0;
        if (launch_addr[1:0] != 2'b00) begin
          fault    <= 1'b1;
          imem_req <= 1'b0;
          state    <= S_HALT;
        end else begin
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= launch_addr;
          wait_cnt  <= '0;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (redirect) begin
              state    <= S_DRAIN;
              wait_cnt <= '0;
            end else if (imem_ack) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= S_HOLD;
            end else if (wait_cnt == CNT_LAST) begin
              fault    <= 1'b1;
              imem_req <= 1'b0;
              state    <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          S_DRAIN: begin
            if (wait_cnt == CNT_LAST) begin
              fault    <= 1'b1;
              imem_req <= 1'b0;
              state    <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized episodes checked every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int unsigned TMO    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fault;
  logic [31:0] pc_seed = 32'h0;

  int n_chk = 0;
  int n_pass = 0;

  fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst_n), .pc_in(pc_in), .pc_next(pc_next), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A fetch is either not yet started, a request in flight (possibly stale
  // after a redirect), an instruction waiting for decode, or halted by a fault.
  bit          m_started, m_out, m_stale, m_valid, m_fault;
  logic [31:0] m_addr, m_instr, m_ipc, m_last;
  int          m_wait;
  logic        e_en;
  logic [31:0] e_nx;

  function automatic logic exp_en();
    return rst_n && !m_fault && (redirect || (m_out && !m_stale && imem_ack));
  endfunction

  function automatic logic [31:0] exp_nx();
    if (!exp_en()) return m_last;
    if (redirect) return redirect_pc;
    return m_addr + 32'd4;
  endfunction

  task automatic m_issue(input logic [31:0] a);
    m_valid = 1'b0;
    if (a[1:0] != 2'b00) begin
      m_fault = 1'b1;
      m_out   = 1'b0;
    end else begin
      m_out   = 1'b1;
      m_stale = 1'b0;
      m_addr  = a;
      m_wait  = 0;
    end
  endtask

  // Model update plus the program counter that feeds pc_in.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 0; m_out = 0; m_stale = 0; m_valid = 0; m_fault = 0;
      m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_last = RST_PC; m_wait = 0;
      pc_in <= pc_seed;
    end else begin
      e_en = exp_en();
      e_nx = exp_nx();
      if (e_en) begin
        m_last = e_nx;
        pc_in <= e_nx;
      end
      if (!m_fault) begin
        if (!m_started) begin
          m_started = 1'b1;
          m_issue(redirect ? redirect_pc : pc_in);
        end else if (m_out) begin
          if (imem_ack) begin
            if (redirect) m_issue(redirect_pc);
            else if (m_stale) m_issue(pc_in);
            else begin
              m_instr = imem_rdata; m_ipc = m_addr; m_valid = 1'b1; m_out = 1'b0;
            end
          end else if (redirect && !m_stale) begin
            m_stale = 1'b1;
            m_wait  = 0;
          end else begin
            m_wait++;
            if (m_wait == int'(TMO)) begin
              m_fault = 1'b1;
              m_out   = 1'b0;
            end
          end
        end else if (m_valid) begin
          if (redirect) m_issue(redirect_pc);
          else if (instr_ready) m_issue(pc_in);
        end
      end
    end
  end

  // Per-cycle comparison against the model (reset values while reset is low).
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_pc_en", 32'(pc_en), 32'h0);
      chk("rst_pc_next", pc_next, RST_PC);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
    end else begin
      chk("imem_req", 32'(imem_req), 32'(m_out));
      chk("imem_addr", imem_addr, m_addr);
      chk("pc_en", 32'(pc_en), 32'(exp_en()));
      chk("pc_next", pc_next, exp_nx());
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rp;
    #1 rst_n = 1'b0;
    tick(); tick();
    mid();
    chk("lit_reset_pc_next", pc_next, 32'h0000_0040);
    chk("lit_reset_req", 32'(imem_req), 32'h0);
    tick(); rst_n = 1'b1;
    mid(); chk("lit_idle_req", 32'(imem_req), 32'h0);
    tick();
    mid(); chk("lit_req0", 32'(imem_req), 32'h1); chk("lit_addr0", imem_addr, 32'h0);
    tick(); mid();
    tick(); imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    mid(); chk("lit_pc_en_ack", 32'(pc_en), 32'h1); chk("lit_pc_next4", pc_next, 32'h4);
    tick(); imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("lit_hold_valid", 32'(instr_valid), 32'h1);
      chk("lit_hold_instr", instr, 32'h13);
      chk("lit_hold_ipc", instr_pc, 32'h0);
      chk("lit_hold_req", 32'(imem_req), 32'h0);
      chk("lit_hold_pc_en", 32'(pc_en), 32'h0);
      tick();
    end
    instr_ready = 1'b1;
    mid(); chk("lit_hs_valid", 32'(instr_valid), 32'h1);
    tick(); instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    mid(); chk("lit_req4", imem_addr, 32'h4); chk("lit_bubble", 32'(instr_valid), 32'h0);
    tick(); imem_ack = 1'b0; instr_ready = 1'b1;
    mid(); chk("lit_ipc4", instr_pc, 32'h4);
    tick(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    mid(); chk("lit_req8", imem_addr, 32'h8); chk("lit_redir_pc", pc_next, 32'h100);
    chk("lit_redir_en", 32'(pc_en), 32'h1);
    tick(); redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    mid(); chk("lit_drain_addr", imem_addr, 32'h8); chk("lit_drain_req", 32'(imem_req), 32'h1);
    tick(); imem_ack = 1'b0;
    mid(); chk("lit_req100", imem_addr, 32'h100); chk("lit_no_valid8", 32'(instr_valid), 32'h0);
    tick(); imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
    tick(); imem_ack = 1'b0;
    mid(); chk("lit_ipc100", instr_pc, 32'h100); chk("lit_instr55", instr, 32'h55);

    // Address wrap at the top of memory.
    tick(); rst_n = 1'b0; pc_seed = 32'hFFFF_FFFC;
    tick(); tick(); rst_n = 1'b1;
    tick(); imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    mid(); chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFFC); chk("lit_wrap_next", pc_next, 32'h0);
    tick(); imem_ack = 1'b0;
    mid(); chk("lit_wrap_ipc", instr_pc, 32'hFFFF_FFFC);

    // Misaligned redirect halts.
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick(); redirect = 1'b0;
    mid(); chk("lit_mis_fault", 32'(fault), 32'h1); chk("lit_mis_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      imem_ack = 1'($urandom_range(0, 1)); redirect = 1'($urandom_range(0, 1));
      redirect_pc = 32'h200; instr_ready = 1'($urandom_range(0, 1));
      mid();
      chk("lit_halt_fault", 32'(fault), 32'h1);
      chk("lit_halt_req", 32'(imem_req), 32'h0);
      chk("lit_halt_pc_en", 32'(pc_en), 32'h0);
    end

    // Acknowledge timeout.
    tick(); rst_n = 1'b0; pc_seed = 32'h0000_0020;
    imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    mid(); chk("lit_fault_cleared", 32'(fault), 32'h0);
    tick(); tick(); rst_n = 1'b1;
    tick();
    mid(); chk("lit_tmo_addr", imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick(); mid(); chk("lit_tmo_wait", 32'(fault), 32'h0);
    end
    tick(); mid(); chk("lit_tmo_fault", 32'(fault), 32'h1); chk("lit_tmo_req", 32'(imem_req), 32'h0);
    tick(); rst_n = 1'b0; pc_seed = 32'h0000_0080;
    mid(); chk("lit_tmo_rst", 32'(fault), 32'h0);
    tick(); tick(); rst_n = 1'b1;
    tick();
    mid(); chk("lit_restart_req", 32'(imem_req), 32'h1); chk("lit_restart_addr", imem_addr, 32'h80);

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      tick(); rst_n = 1'b0;
      imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
      pc_seed = (ep % 5 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      if (ep % 7 == 3) pc_seed = pc_seed | 32'h1;
      tick(); tick(); rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
        tick();
        rst_n = ($urandom_range(0, 99) != 0);
        imem_ack = ($urandom_range(0, 9) < 6);
        imem_rdata = $urandom;
        redirect = ($urandom_range(0, 9) == 0);
        rp = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 29) == 0) rp = rp | 32'($urandom_range(1, 3));
        redirect_pc = rp;
        instr_ready = 1'($urandom_range(0, 1));
      end
    end
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
